// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// Byte-enable merge is sized for the widest supported word.
package register_file_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

  localparam int RF_MAX_DW = 1024;
  localparam int RF_MAX_BE = RF_MAX_DW / 8;

  function automatic int rf_bytes(input int dw);
    return dw / 8;
  endfunction

  function automatic logic [RF_MAX_DW-1:0] be_merge(
    input logic [RF_MAX_DW-1:0] old_w,
    input logic [RF_MAX_DW-1:0] new_w,
    input logic [RF_MAX_BE-1:0] be
  );
    logic [RF_MAX_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < RF_MAX_BE; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/register_file_bank.sv
// One storage copy: a registered read port, a byte-enabled write
// port and an optional same-address write-first bypass.
module register_file_bank
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 64,
  parameter int WRITE_FIRST = 1,
  localparam int NB = rf_bytes(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [NB-1:0]         wbe_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] wword;
  logic                  hit;

  assign wword = DATA_WIDTH'(be_merge(
    RF_MAX_DW'(mem_q[waddr_i]),
    RF_MAX_DW'(wdata_i),
    RF_MAX_BE'(wbe_i)));

  assign hit = (WRITE_FIRST != 0) && we_i
            && (raddr_i == waddr_i);

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      if (clear_i)  rdata_d = '0;
      else if (hit) rdata_d = wword;
      else          rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wword;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/register_file_nr_1w_be.sv
// N-read / 1-write byte-enabled register file with a clear sequencer.
// Each read port owns a replicated bank fed by one shared write port.
module register_file_nr_1w_be
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 64,
  parameter int N_READ         = 2,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB = rf_bytes(DATA_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ClearReq,
  output logic                                 Busy,
  input  logic [N_READ-1:0]                    ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]    ReadAddr,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]    ReadData,
  input  logic                                 WriteEnable,
  input  logic [ADDR_WIDTH-1:0]                WriteAddr,
  input  logic [NB-1:0]                        WriteBe,
  input  logic [DATA_WIDTH-1:0]                WriteData
);

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > RF_MAX_DW
      || N_READ < 1) begin : g_bad_cfg
    $error("register_file_nr_1w_be: bad DATA_WIDTH/N_READ");
  end

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy;
  logic                  we_w;
  logic [ADDR_WIDTH-1:0] waddr_w;
  logic [NB-1:0]         wbe_w;
  logic [DATA_WIDTH-1:0] wdata_w;

  assign busy = (state_q == RF_CLEAR);
  assign Busy = busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_IDLE: begin
        if (ClearReq) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep owns the write port; external writes are dropped meanwhile.
  assign we_w    = !rst && (busy || WriteEnable);
  assign waddr_w = busy ? cnt_q : WriteAddr;
  assign wbe_w   = busy ? '1 : WriteBe;
  assign wdata_w = busy ? '0 : WriteData;

  for (genvar p = 0; p < N_READ; p++) begin : g_bank
    register_file_bank #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .WRITE_FIRST (WRITE_FIRST)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .clear_i (busy),
      .re_i    (ReadEnable[p]),
      .raddr_i (ReadAddr[p]),
      .rdata_o (ReadData[p]),
      .we_i    (we_w),
      .waddr_i (waddr_w),
      .wbe_i   (wbe_w),
      .wdata_i (wdata_w)
    );
  end

endmodule

// File: tb/tb_register_file_nr_1w_be.sv
// Bench for register_file_nr_1w_be: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_register_file_nr_1w_be;

  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int NR    = 2;
  localparam int WF    = 1;
  localparam int COR   = 1;
  localparam int DEPTH = 2**AW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ClearReq;
  logic                   Busy;
  logic [NR-1:0]          ReadEnable;
  logic [NR-1:0][AW-1:0]  ReadAddr;
  logic [NR-1:0][DW-1:0]  ReadData;
  logic                   WriteEnable;
  logic [AW-1:0]          WriteAddr;
  logic [DW/8-1:0]        WriteBe;
  logic [DW-1:0]          WriteData;

  always #5 clk = ~clk;

  register_file_nr_1w_be #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .N_READ         (NR),
    .WRITE_FIRST    (WF),
    .CLEAR_ON_RESET (COR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ClearReq    (ClearReq),
    .Busy        (Busy),
    .ReadEnable  (ReadEnable),
    .ReadAddr    (ReadAddr),
    .ReadData    (ReadData),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteBe     (WriteBe),
    .WriteData   (WriteData)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rd  [NR];
  int            sweep_left = 0;
  int            sweep_pos  = 0;
  logic          exp_busy   = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                          input logic [DW-1:0] n,
                                          input logic [DW/8-1:0] be);
    for (int b = 0; b < DW/8; b++)
      if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  task automatic model_update();
    logic bz;
    if (rst) begin
      for (int p = 0; p < NR; p++) exp_rd[p] = '0;
      sweep_left = (COR != 0) ? DEPTH : 0;
      sweep_pos  = 0;
    end else begin
      bz = sweep_left > 0;
      for (int p = 0; p < NR; p++) begin
        if (ReadEnable[p]) begin
          if (bz)
            exp_rd[p] = '0;
          else if (WF != 0 && WriteEnable && ReadAddr[p] == WriteAddr)
            exp_rd[p] = merge(ref_mem[WriteAddr], WriteData, WriteBe);
          else
            exp_rd[p] = ref_mem[ReadAddr[p]];
        end
      end
      if (bz) begin
        ref_mem[sweep_pos] = '0;
        sweep_pos++;
        sweep_left--;
      end else begin
        if (WriteEnable)
          ref_mem[WriteAddr] = merge(ref_mem[WriteAddr], WriteData, WriteBe);
        if (ClearReq) begin
          sweep_left = DEPTH;
          sweep_pos  = 0;
        end
      end
    end
    exp_busy = sweep_left > 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("busy", 64'(Busy), 64'(exp_busy));
    for (int p = 0; p < NR; p++)
      check($sformatf("rdata%0d", p), ReadData[p], exp_rd[p]);
  endtask

  task automatic idle_inputs();
    rst         = 1'b0;
    ClearReq    = 1'b0;
    ReadEnable  = '0;
    WriteEnable = 1'b0;
    WriteBe     = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100 && Busy; i++) begin
      n++;
      step();
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [DW/8-1:0] be);
    WriteEnable = 1'b1;
    WriteAddr   = a;
    WriteData   = d;
    WriteBe     = be;
    step();
    WriteEnable = 1'b0;
  endtask

  task automatic rd_both(input logic [AW-1:0] a);
    ReadEnable  = '1;
    ReadAddr[0] = a;
    ReadAddr[1] = a;
    step();
    ReadEnable  = '0;
  endtask

  int n;

  initial begin
    idle_inputs();
    ReadAddr  = '0;
    WriteAddr = '0;
    WriteData = '0;
    for (int p = 0; p < NR; p++) exp_rd[p] = '0;

    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    check("reset_sweep_len", 64'(n), 64'(DEPTH));

    for (int a = 0; a < DEPTH; a++) begin
      rd_both(AW'(a));
      check("cleared", ReadData[0] | ReadData[1], 64'h0);
    end

    wr(5'd3, 64'h1122334455667788, 8'hFF);
    wr(5'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    wr(5'd4, 64'h0123456789ABCDEF, 8'h00);
    rd_both(5'd3);
    check("be_merge", ReadData[0], 64'h11223344AAAAAAAA);
    rd_both(5'd4);
    check("be_zero", ReadData[1], 64'h0);

    wr(5'd7, 64'h5, 8'hFF);
    WriteEnable = 1'b1;
    WriteAddr   = 5'd7;
    WriteData   = 64'hDEAD_BEEF_0000_0001;
    WriteBe     = 8'hFF;
    ReadEnable  = 2'b11;
    ReadAddr[0] = 5'd7;
    ReadAddr[1] = 5'd8;
    step();
    idle_inputs();
    check("rdw_p0", ReadData[0],
          (WF != 0) ? 64'hDEADBEEF00000001 : 64'h5);
    check("rdw_p1", ReadData[1], 64'h0);

    wr(5'd9, 64'h9999_0000_9999_0000, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      ReadEnable  = NR'(i + 1);
      ReadAddr[0] = (i % 2 != 0) ? 5'd9 : 5'd3;
      ReadAddr[1] = (i % 2 != 0) ? 5'd3 : 5'd9;
      step();
    end
    idle_inputs();

    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    for (int i = 0; i < 10; i++) step();
    ClearReq = 1'b1;
    wr(5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    ClearReq = 1'b0;
    count_busy(n);
    check("req_sweep_len", 64'(n + 11), 64'(DEPTH));
    rd_both(5'd2);
    check("dropped_write", ReadData[0], 64'h0);

    wr(5'd2, 64'h1234, 8'hFF);
    rd_both(5'd2);
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_rdata", ReadData[0] | ReadData[1], 64'h0);
    count_busy(n);
    check("rst_sweep_len", 64'(n), 64'(DEPTH));

    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 499) == 0);
      ClearReq    = ($urandom_range(0, 99) == 0);
      ReadEnable  = NR'($urandom);
      ReadAddr[0] = AW'($urandom);
      ReadAddr[1] = ($urandom_range(0, 3) == 0) ? ReadAddr[0]
                                                : AW'($urandom);
      WriteEnable = $urandom_range(0, 1) == 1;
      WriteAddr   = ($urandom_range(0, 3) == 0) ? ReadAddr[0]
                                                : AW'($urandom);
      WriteBe     = (DW/8)'($urandom);
      WriteData   = {$urandom, $urandom};
      step();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
